// File: rtl/iiitb_usr_pkg.sv
// Shared encodings for the shift-register command sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: select encodings, sequencer FSM state type, command FIFO depth.
package iiitb_usr_pkg;

    localparam logic [1:0] SEL_LEFT  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LOAD  = 2'b10;
    localparam logic [1:0] SEL_HOLD  = 2'b11;

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iiitb_usr_cmd_fifo.sv
// Small command FIFO holding {op, count, data} words ahead of the sequencer FSM.
// Latency: a word written at edge N is visible on o_dat (o_empty=0) right after edge N.
// Backpressure: writes while full and reads while empty are ignored; o_full is registered state.
//
// Ports: clock, clear (async active-high), i_wr/i_dat write side,
//        i_rd/o_dat read side (show-ahead), o_full, o_empty.
module iiitb_usr_cmd_fifo
    import iiitb_usr_pkg::*;
#(
    parameter int DW    = 14,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          i_wr,
    input  logic [DW-1:0] i_dat,
    input  logic          i_rd,
    output logic [DW-1:0] o_dat,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_wr    = i_wr && !o_full;
    assign w_rd    = i_rd && !o_empty;
    assign o_dat   = r_mem[r_rd_ptr];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers/count.
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/iiitb_usr_seq.sv
// Command sequencer driving a universal shift register's select/data_in for N cycles per command.
// Latency: RUN starts on the transfer edge (one edge later through the FIFO); done pulses after the last RUN cycle.
// Backpressure: cmd_ready only in IDLE, or !full when IIITB_USR_SEQ_FIFO_EN is defined.
//
// Ports: clock, clear (async active-high), cmd_valid/cmd_ready/cmd_op/cmd_count/cmd_data command
//        input; select/data_in registered shift-register drive; busy, done status.
// Build option: IIITB_USR_SEQ_FIFO_EN adds a 4-entry command FIFO in front of the FSM.
module iiitb_usr_seq
    import iiitb_usr_pkg::*;
#(
    parameter int MSB   = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [MSB-1:0]   cmd_data,
    output logic [1:0]       select,
    output logic [MSB-1:0]   data_in,
    output logic             busy,
    output logic             done
);

    state_t             r_state;
    logic [1:0]         r_select;
    logic [MSB-1:0]     r_data;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_start;
    logic [1:0]         w_op;
    logic [CNT_W-1:0]   w_cnt;
    logic [MSB-1:0]     w_dat;

    // Load always runs once; a zero count on other ops still runs once.
    function automatic logic [CNT_W-1:0] eff_count(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
        if (op == SEL_LOAD || cnt == '0) return CNT_W'(1);
        return cnt;
    endfunction

`ifdef IIITB_USR_SEQ_FIFO_EN
    localparam int EW = 2 + CNT_W + MSB;

    logic [EW-1:0] w_fifo_dat;
    logic          w_full;
    logic          w_empty;

    // Ready comes from the registered full flag, so a write into a full FIFO
    // is refused even if a pop happens on the same edge.
    assign cmd_ready = !w_full && !clear;
    assign w_start   = !w_empty && (r_state == IDLE || r_state == DONE);
    assign {w_op, w_cnt, w_dat} = w_fifo_dat;

    iiitb_usr_cmd_fifo #(
        .DW    (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clock   (clock),
        .clear   (clear),
        .i_wr    (cmd_valid && cmd_ready),
        .i_dat   ({cmd_op, cmd_count, cmd_data}),
        .i_rd    (w_start),
        .o_dat   (w_fifo_dat),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
`else
    assign cmd_ready = (r_state == IDLE) && !clear;
    assign w_start   = cmd_valid && cmd_ready;
    assign w_op      = cmd_op;
    assign w_cnt     = cmd_count;
    assign w_dat     = cmd_data;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state  <= IDLE;
            r_select <= SEL_HOLD;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // Without the FIFO w_start can only be true in IDLE, so DONE
                // always falls back to IDLE in that build.
                IDLE, DONE: begin
                    if (w_start) begin
                        r_state  <= RUN;
                        r_select <= w_op;
                        r_data   <= w_dat;
                        r_busy   <= 1'b1;
                        r_cnt    <= eff_count(w_op, w_cnt);
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state  <= DONE;
                        r_select <= SEL_HOLD;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_select <= SEL_HOLD;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign select  = r_select;
    assign data_in = r_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
